// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;
  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED,
    STEP
  } hz_state_t;
  localparam int DEFAULT_DRAIN_CYCLES = 3;
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// fwd_sel: E-stage operand bypass select for one source register, M over W
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] addr_m,
  input  logic       en_m,
  input  logic [4:0] addr_w,
  input  logic       en_w,
  output fwd_sel_t   sel
);
  logic w_hit_m;
  logic w_hit_w;
  assign w_hit_m = en_m && addr_m != 5'd0 && addr_m == src;
  assign w_hit_w = en_w && addr_w != 5'd0 && addr_w == src;
  assign sel = w_hit_m ? FWD_M : w_hit_w ? FWD_W : FWD_REG;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use stall, branch flush, debug halt/step FSM
// and saturating stall/flush counters for the 5-stage MIPS pipeline
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       regWriteAddrE,
  input  logic [4:0]       regWriteAddrM,
  input  logic [4:0]       regWriteAddrW,
  input  logic             RegWriteEnableE,
  input  logic             RegWriteEnableM,
  input  logic             RegWriteEnableW,
  input  logic             MemtoRegE,
  input  logic             BranchM,
  input  logic             zeroM,
  input  logic             haltReq,
  input  logic             stepReq,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             forwardAD,
  output logic             forwardBD,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             pcSrcM,
  output logic             halted,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt
);
  localparam int DC_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DC_W-1:0] DC_INIT = DC_W'(DRAIN_CYCLES - 1);
  hz_state_t        r_state;
  hz_state_t        w_state_n;
  logic [DC_W-1:0]  r_dc;
  logic [DC_W-1:0]  w_dc_n;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  fwd_sel_t         w_fa;
  fwd_sel_t         w_fb;
  logic             w_lu;
  logic             w_tk;
  logic             w_hold;
  logic             w_stall_inc;
  fwd_sel u_fwd_a (
    .src(rsE), .addr_m(regWriteAddrM), .en_m(RegWriteEnableM),
    .addr_w(regWriteAddrW), .en_w(RegWriteEnableW), .sel(w_fa)
  );
  fwd_sel u_fwd_b (
    .src(rtE), .addr_m(regWriteAddrM), .en_m(RegWriteEnableM),
    .addr_w(regWriteAddrW), .en_w(RegWriteEnableW), .sel(w_fb)
  );
  assign forwardAE = w_fa;
  assign forwardBE = w_fb;
  assign forwardAD = RegWriteEnableW && regWriteAddrW != 5'd0 && regWriteAddrW == rsD;
  assign forwardBD = RegWriteEnableW && regWriteAddrW != 5'd0 && regWriteAddrW == rtD;
  // RegWriteEnableE is not needed: a load always writes its destination
  assign w_lu = MemtoRegE && regWriteAddrE != 5'd0 &&
                (regWriteAddrE == rsD || regWriteAddrE == rtD);
  assign w_tk = BranchM && zeroM;
  // Pipeline is frozen in DRAIN/HALTED; STEP lets exactly one instruction through
  assign w_hold = (r_state == RUN) ? w_lu : (r_state != STEP);
  assign stallF = w_hold && !w_tk;
  assign stallD = w_hold && !w_tk;
  assign flushE = w_hold || w_tk;
  assign flushD = w_tk;
  assign flushM = w_tk;
  assign pcSrcM = w_tk;
  assign halted = r_state == HALTED;
  assign stallCnt = r_stall_cnt;
  assign flushCnt = r_flush_cnt;
  assign w_stall_inc = r_state == RUN && w_lu && !w_tk;
  always_comb begin
    w_state_n = r_state;
    w_dc_n = r_dc;
    case (r_state)
      RUN: begin
        w_state_n = haltReq ? DRAIN : RUN;
        w_dc_n = haltReq ? DC_INIT : r_dc;
      end
      DRAIN: begin
        w_state_n = (r_dc == '0) ? HALTED : DRAIN;
        w_dc_n = (r_dc == '0) ? r_dc : r_dc - 1'b1;
      end
      HALTED: w_state_n = !haltReq ? RUN : stepReq ? STEP : HALTED;
      STEP: begin
        w_state_n = DRAIN;
        w_dc_n = DC_INIT;
      end
      default: w_state_n = RUN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_dc <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_n;
      r_dc <= w_dc_n;
      if (w_stall_inc && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_tk && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed-vector self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  logic       clk = 0;
  logic       reset;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic [4:0] regWriteAddrE, regWriteAddrM, regWriteAddrW;
  logic       RegWriteEnableE, RegWriteEnableM, RegWriteEnableW;
  logic       MemtoRegE, BranchM, zeroM, haltReq, stepReq;
  logic [1:0] forwardAE, forwardBE;
  logic       forwardAD, forwardBD, stallF, stallD, flushD, flushE, flushM;
  logic       pcSrcM, halted;
  logic [3:0] stallCnt, flushCnt;
  int         total = 0;
  int         bad = 0;
  always #5 clk = ~clk;
  hazard_ctrl #(.CNT_W(4), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .regWriteAddrE(regWriteAddrE), .regWriteAddrM(regWriteAddrM),
    .regWriteAddrW(regWriteAddrW),
    .RegWriteEnableE(RegWriteEnableE), .RegWriteEnableM(RegWriteEnableM),
    .RegWriteEnableW(RegWriteEnableW),
    .MemtoRegE(MemtoRegE), .BranchM(BranchM), .zeroM(zeroM),
    .haltReq(haltReq), .stepReq(stepReq),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .pcSrcM(pcSrcM), .halted(halted),
    .stallCnt(stallCnt), .flushCnt(flushCnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  initial begin
    reset = 1;
    {rsD, rtD, rsE, rtE} = '0;
    {regWriteAddrE, regWriteAddrM, regWriteAddrW} = '0;
    {RegWriteEnableE, RegWriteEnableM, RegWriteEnableW} = '0;
    {MemtoRegE, BranchM, zeroM, haltReq, stepReq} = '0;
    tick();
    tick();
    reset = 0;
    settle();
    chk("rst_halted", halted, 0);
    chk("rst_stallcnt", stallCnt, 0);
    chk("rst_flushcnt", flushCnt, 0);
    chk("rst_stallF", stallF, 0);
    chk("rst_flushE", flushE, 0);
    // forwarding
    regWriteAddrM = 5; RegWriteEnableM = 1;
    regWriteAddrW = 5; RegWriteEnableW = 1;
    rsE = 5; rtE = 5; rsD = 5; rtD = 7;
    settle();
    chk("fwdAE_M", forwardAE, 2'b10);
    chk("fwdBE_M", forwardBE, 2'b10);
    chk("fwdAD_W", forwardAD, 1);
    chk("fwdBD_none", forwardBD, 0);
    RegWriteEnableM = 0;
    settle();
    chk("fwdAE_W", forwardAE, 2'b01);
    rsE = 0; rtE = 0; rsD = 0;
    regWriteAddrM = 0; regWriteAddrW = 0; RegWriteEnableM = 1;
    settle();
    chk("fwdAE_zero", forwardAE, 2'b00);
    chk("fwdBE_zero", forwardBE, 2'b00);
    chk("fwdAD_zero", forwardAD, 0);
    RegWriteEnableM = 0; RegWriteEnableW = 0;
    // load-use
    MemtoRegE = 1; RegWriteEnableE = 1; regWriteAddrE = 8; rtD = 8;
    settle();
    chk("lu_stallF", stallF, 1);
    chk("lu_stallD", stallD, 1);
    chk("lu_flushE", flushE, 1);
    chk("lu_flushD", flushD, 0);
    tick();
    chk("lu_stallcnt", stallCnt, 1);
    MemtoRegE = 0;
    settle();
    chk("nolu_stallF", stallF, 0);
    chk("nolu_flushE", flushE, 0);
    tick();
    chk("nolu_stallcnt", stallCnt, 1);
    // branch over load-use
    MemtoRegE = 1; BranchM = 1; zeroM = 1;
    settle();
    chk("br_pcsrc", pcSrcM, 1);
    chk("br_flushD", flushD, 1);
    chk("br_flushE", flushE, 1);
    chk("br_flushM", flushM, 1);
    chk("br_stallF", stallF, 0);
    chk("br_stallD", stallD, 0);
    tick();
    chk("br_stallcnt", stallCnt, 1);
    chk("br_flushcnt", flushCnt, 1);
    zeroM = 0;
    settle();
    chk("nt_pcsrc", pcSrcM, 0);
    chk("nt_stallF", stallF, 1);
    MemtoRegE = 0; BranchM = 0; regWriteAddrE = 0; rtD = 0;
    // halt: exactly three drain cycles
    haltReq = 1;
    settle();
    chk("hreq_run_stallF", stallF, 0);
    tick();
    BranchM = 1; zeroM = 1;
    settle();
    chk("drain_tk_stallF", stallF, 0);
    chk("drain_tk_pcsrc", pcSrcM, 1);
    chk("drain_tk_flushM", flushM, 1);
    BranchM = 0; zeroM = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("drain_stallF", stallF, 1);
      chk("drain_halted", halted, 0);
      tick();
    end
    chk("halted", halted, 1);
    chk("halted_stallF", stallF, 1);
    chk("halted_flushE", flushE, 1);
    // single step
    stepReq = 1;
    tick();
    stepReq = 0;
    settle();
    chk("step_stallF", stallF, 0);
    chk("step_flushE", flushE, 0);
    chk("step_halted", halted, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("sdrain_stallF", stallF, 1);
      chk("sdrain_halted", halted, 0);
      tick();
    end
    chk("step_rehalted", halted, 1);
    haltReq = 0;
    settle();
    chk("resume_still_halted", halted, 1);
    tick();
    chk("resume_run", halted, 0);
    chk("resume_stallF", stallF, 0);
    // haltReq dropped mid-drain: drain still completes
    haltReq = 1;
    tick();
    haltReq = 0;
    tick();
    tick();
    chk("mid_drop_halted0", halted, 0);
    tick();
    chk("mid_drop_halted1", halted, 1);
    tick();
    chk("mid_drop_run", halted, 0);
    // sync reset during drain (dc=1)
    haltReq = 1;
    tick();
    tick();
    haltReq = 0;
    reset = 1;
    settle();
    chk("rst_sync_stallF", stallF, 1);
    chk("rst_sync_cnt", flushCnt, 1);
    tick();
    reset = 0;
    settle();
    chk("rst_mid_halted", halted, 0);
    chk("rst_mid_stallF", stallF, 0);
    chk("rst_mid_stallcnt", stallCnt, 0);
    chk("rst_mid_flushcnt", flushCnt, 0);
    tick();
    tick();
    tick();
    chk("rst_mid_nohalt", halted, 0);
    // saturation
    MemtoRegE = 1; regWriteAddrE = 9; rsD = 9;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stallcnt", stallCnt, 4'hF);
    MemtoRegE = 0; BranchM = 1; zeroM = 1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_flushcnt", flushCnt, 4'hF);
    chk("sat_stallcnt_hold", stallCnt, 4'hF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
